// File: rtl/mmio_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_arbiter
// Brief    : N-channel MMIO arbiter with ack/timeout handshake and IRQ CSRs
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_arbiter #(
  parameter int                WORD_SIZE = 64,
  parameter int                ADDR_W    = 20,
  parameter int                IO_COUNT  = 4,
  parameter int                WIN_BITS  = 5,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'('h00000),
  parameter logic [ADDR_W-1:0] CSR_BASE  = ADDR_W'('h00080),
  parameter int                TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_dir,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [WORD_SIZE-1:0]          req_wdata,
  output logic                          rsp_valid,
  output logic [WORD_SIZE-1:0]          rsp_rdata,
  output logic                          rsp_err,
  output logic [IO_COUNT-1:0]           io_req,
  output logic                          io_dir,
  output logic [WIN_BITS-1:0]           io_addr,
  output logic [WORD_SIZE-1:0]          io_wdata,
  input  logic [IO_COUNT-1:0]           io_ack,
  input  logic [IO_COUNT*WORD_SIZE-1:0] io_rdata,
  input  logic [IO_COUNT-1:0]           io_irq,
  output logic                          irq_out
);

  localparam int                SEL_W         = (IO_COUNT > 1) ? $clog2(IO_COUNT) : 1;
  localparam logic [ADDR_W-1:0] c_status_addr = CSR_BASE;
  localparam logic [ADDR_W-1:0] c_mask_addr   = CSR_BASE + ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEV_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [7:0]          r_cnt;
  logic [IO_COUNT-1:0] r_pending;
  logic [IO_COUNT-1:0] r_mask;
  logic [IO_COUNT-1:0] r_irq_prev;

  logic [ADDR_W-1:0]    w_offset;
  logic [ADDR_W-1:0]    w_ch_idx;
  logic [SEL_W-1:0]     w_sel;
  logic [IO_COUNT-1:0]  w_onehot;
  logic                 w_dev_hit;
  logic                 w_status_hit;
  logic                 w_mask_hit;
  logic                 w_accept;
  logic                 w_status_rd;
  logic                 w_mask_wr;
  logic                 w_ack;
  logic [WORD_SIZE-1:0] w_dev_rdata;
  logic [IO_COUNT-1:0]  w_rise;

  assign req_ready    = (r_state == ST_IDLE);
  assign w_accept     = req_valid && (r_state == ST_IDLE);

  // Offset below IO_BASE wraps, so the lower-bound compare guards the decode.
  assign w_offset     = req_addr - IO_BASE;
  assign w_ch_idx     = w_offset >> WIN_BITS;
  assign w_sel        = w_ch_idx[SEL_W-1:0];
  assign w_onehot     = IO_COUNT'(1) << w_sel;
  assign w_dev_hit    = (req_addr >= IO_BASE) && (w_ch_idx < ADDR_W'(IO_COUNT));
  assign w_status_hit = (req_addr == c_status_addr);
  assign w_mask_hit   = (req_addr == c_mask_addr);

  assign w_status_rd  = w_accept && !w_dev_hit && w_status_hit && req_dir;
  assign w_mask_wr    = w_accept && !w_dev_hit && w_mask_hit && !req_dir;

  assign w_ack        = io_ack[r_sel];
  assign w_dev_rdata  = io_rdata[r_sel*WORD_SIZE +: WORD_SIZE];
  assign w_rise       = io_irq & ~r_irq_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      io_req    <= '0;
      io_dir    <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          if (w_accept) begin
            io_dir   <= req_dir;
            io_addr  <= w_offset[WIN_BITS-1:0];
            io_wdata <= req_wdata;
            r_cnt    <= '0;
            if (w_dev_hit) begin
              io_req  <= w_onehot;
              r_sel   <= w_sel;
              r_state <= ST_DEV_WAIT;
            end else begin
              rsp_valid <= 1'b1;
              r_state   <= ST_RESP;
              if (w_status_hit) begin
                rsp_rdata <= req_dir ? WORD_SIZE'(r_pending) : '0;
              end else if (w_mask_hit) begin
                rsp_rdata <= req_dir ? WORD_SIZE'(r_mask) : '0;
              end else begin
                rsp_err <= 1'b1;
              end
            end
          end
        end

        ST_DEV_WAIT: begin
          // An ack arriving on the expiry edge takes priority over the timeout.
          if (w_ack) begin
            io_req    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= io_dir ? w_dev_rdata : '0;
            r_state   <= ST_RESP;
          end else if (r_cnt == 8'(TIMEOUT)) begin
            io_req    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          r_state   <= ST_IDLE;
        end

        default: begin
          io_req    <= '0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // A STATUS read clears what it returned; a fresh edge in that cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      irq_out    <= 1'b0;
    end else begin
      r_irq_prev <= io_irq;
      r_pending  <= w_status_rd ? w_rise : (r_pending | w_rise);
      if (w_mask_wr) begin
        r_mask <= req_wdata[IO_COUNT-1:0];
      end
      irq_out <= |(r_pending & r_mask);
    end
  end

endmodule
`default_nettype wire
